// File: rtl/uart_host_pkg.sv
// Shared definitions for the host-side UART command sequencer.
//   - cmd_type encodings and sequencer state encoding
//   - frame opcodes placed in byte 0 of every command frame
//   - frame-length and response-length lookup functions
package uart_host_pkg;

    typedef enum logic [1:0] {
        CMD_RF_WR   = 2'd0,
        CMD_RF_RD   = 2'd1,
        CMD_ALU_OP  = 2'd2,
        CMD_ALU_NOP = 2'd3
    } cmd_type_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } state_e;

    localparam logic [7:0] OPC_RF_WR   = 8'hAA;
    localparam logic [7:0] OPC_RF_RD   = 8'hBB;
    localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
    localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

    // Index of the final byte of a command frame (frame length - 1).
    function automatic logic [1:0] frame_last_idx(cmd_type_e t);
        case (t)
            CMD_RF_WR:  return 2'd2;
            CMD_RF_RD:  return 2'd1;
            CMD_ALU_OP: return 2'd3;
            default:    return 2'd1;
        endcase
    endfunction

    // Number of response bytes the far end returns for a command.
    function automatic int rsp_len(cmd_type_e t, int rsp_bytes);
        case (t)
            CMD_RF_WR: return 0;
            CMD_RF_RD: return 1;
            default:   return rsp_bytes;
        endcase
    endfunction

endpackage

// File: rtl/host_rsp_timer.sv
// Response inter-byte timer for the host command sequencer.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   run        high while the sequencer waits for response bytes
//   rx_strobe  response byte arrived this cycle (restarts the count)
//   tc         terminal count: the wait has run out
module host_rsp_timer #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic rx_strobe,
    output logic tc
);

    // The strobe cycle itself counts as cycle 0 of the gap, so the first
    // silent cycle sees 1; tc is raised one cycle early so the completion
    // cycle lands exactly TIMEOUT_CYCLES cycles after the last byte.
    localparam logic [15:0] TC_VAL = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt_q <= '0;
        end else if (rx_strobe) begin
            cnt_q <= 16'd1;
        end else if (cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign tc = run && !rx_strobe && (cnt_q >= TC_VAL);

endmodule

// File: rtl/uart_host_cmd_seq.sv
// Host-side command sequencer: accepts one command, streams its frame bytes
// to a UART TX byte adapter and gathers the response bytes from a UART RX
// byte adapter, then pulses rsp_valid.
// Ports:
//   CLK, RST                   clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//   cmd_type/addr/data/op_b/fun command fields, latched on accept
//   tx_byte/tx_valid/tx_ready  frame byte stream to UART TX
//   rx_byte/rx_valid           response byte strobe from UART RX
//   rsp_valid                  one-cycle completion pulse
//   rsp_data                   response bytes, LSB-first, zero-padded
//   rsp_timeout                response ended by timeout (partial data)
//   rx_unexpected              pulse: rx byte arrived while not expected
//   busy                       ~cmd_ready
// Optional feature: define HOST_RSP_TIMEOUT_EN to enable the response
// timeout; otherwise WAIT_RSP waits indefinitely and rsp_timeout is 0.
module uart_host_cmd_seq
    import uart_host_pkg::*;
#(
    parameter int ADDR_WIDTH     = 4,
    parameter int RSP_BYTES      = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_type,
    input  logic [ADDR_WIDTH-1:0]  cmd_addr,
    input  logic [7:0]             cmd_data,
    input  logic [7:0]             cmd_op_b,
    input  logic [3:0]             cmd_fun,
    output logic [7:0]             tx_byte,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    input  logic [7:0]             rx_byte,
    input  logic                   rx_valid,
    output logic                   rsp_valid,
    output logic [8*RSP_BYTES-1:0] rsp_data,
    output logic                   rsp_timeout,
    output logic                   rx_unexpected,
    output logic                   busy
);

    localparam int RX_IDX_W = $clog2(RSP_BYTES + 1);

    state_e                  state_q, state_d;
    cmd_type_e               type_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              data_q, op_b_q;
    logic [3:0]              fun_q;
    logic [1:0]              tx_idx_q;
    logic [RX_IDX_W-1:0]     rx_idx_q, rx_idx_inc, rsp_len_q;
    logic [8*RSP_BYTES-1:0]  rsp_data_q;
    logic                    rx_unexpected_q;
    logic                    accept, tx_hs, tx_last, rx_store, timeout_hit;
    logic [7:0]              frame_byte;

    assign cmd_ready     = (state_q == IDLE) && !RST;
    assign busy          = ~cmd_ready;
    assign accept        = cmd_valid && cmd_ready;
    assign tx_valid      = (state_q == SEND);
    assign tx_hs         = tx_valid && tx_ready;
    assign tx_last       = (tx_idx_q == frame_last_idx(type_q));
    assign tx_byte       = tx_valid ? frame_byte : 8'h00;
    assign rx_idx_inc    = rx_idx_q + RX_IDX_W'(1);
    assign rsp_valid     = (state_q == DONE);
    assign rsp_data      = rsp_data_q;
    assign rx_unexpected = rx_unexpected_q;

    // A byte that lands on the final tx handshake already belongs to the
    // response, as long as this command expects one.
    assign rx_store = rx_valid &&
                      ((state_q == WAIT_RSP) ||
                       ((state_q == SEND) && tx_hs && tx_last && (rsp_len_q != '0)));

`ifdef HOST_RSP_TIMEOUT_EN
    logic rsp_tc;
    logic rsp_timeout_q;

    host_rsp_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rsp_timer (
        .clk       (CLK),
        .rst       (RST),
        .run       (state_q == WAIT_RSP),
        .rx_strobe (rx_valid),
        .tc        (rsp_tc)
    );

    assign timeout_hit = (state_q == WAIT_RSP) && rsp_tc;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rsp_timeout_q <= 1'b0;
        end else if (accept) begin
            rsp_timeout_q <= 1'b0;
        end else if (timeout_hit) begin
            rsp_timeout_q <= 1'b1;
        end
    end

    assign rsp_timeout = rsp_timeout_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_comb begin
        frame_byte = 8'h00;
        case (type_q)
            CMD_RF_WR: begin
                case (tx_idx_q)
                    2'd0:    frame_byte = OPC_RF_WR;
                    2'd1:    frame_byte = 8'(addr_q);
                    default: frame_byte = data_q;
                endcase
            end
            CMD_RF_RD:
                frame_byte = (tx_idx_q == 2'd0) ? OPC_RF_RD : 8'(addr_q);
            CMD_ALU_OP: begin
                case (tx_idx_q)
                    2'd0:    frame_byte = OPC_ALU_OP;
                    2'd1:    frame_byte = data_q;
                    2'd2:    frame_byte = op_b_q;
                    default: frame_byte = {4'h0, fun_q};
                endcase
            end
            default:
                frame_byte = (tx_idx_q == 2'd0) ? OPC_ALU_NOP : {4'h0, fun_q};
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = SEND;
            end
            SEND: begin
                if (tx_hs && tx_last) begin
                    if ((rsp_len_q == '0) ||
                        (rx_valid && (rsp_len_q == RX_IDX_W'(1)))) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                if (rx_valid) begin
                    if (rx_idx_inc == rsp_len_q) state_d = DONE;
                end else if (timeout_hit) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Command fields are plain data: captured on accept, never reset.
    always_ff @(posedge CLK) begin
        if (accept) begin
            type_q <= cmd_type_e'(cmd_type);
            addr_q <= cmd_addr;
            data_q <= cmd_data;
            op_b_q <= cmd_op_b;
            fun_q  <= cmd_fun;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_idx_q        <= '0;
            rx_idx_q        <= '0;
            rsp_len_q       <= '0;
            rsp_data_q      <= '0;
            rx_unexpected_q <= 1'b0;
        end else begin
            rx_unexpected_q <= rx_valid && !rx_store;
            if (accept) begin
                tx_idx_q   <= '0;
                rx_idx_q   <= '0;
                rsp_len_q  <= RX_IDX_W'(rsp_len(cmd_type_e'(cmd_type), RSP_BYTES));
                rsp_data_q <= '0;
            end else begin
                if (tx_hs && !tx_last) tx_idx_q <= tx_idx_q + 2'd1;
                if (rx_store) begin
                    rsp_data_q[8*rx_idx_q +: 8] <= rx_byte;
                    rx_idx_q                    <= rx_idx_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_host_cmd_seq.sv
module tb_uart_host_cmd_seq;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_type = 2'd0;
    logic [3:0]  cmd_addr = 4'd0;
    logic [7:0]  cmd_data = 8'd0;
    logic [7:0]  cmd_op_b = 8'd0;
    logic [3:0]  cmd_fun = 4'd0;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_byte = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_timeout;
    logic        rx_unexpected;
    logic        busy;

    always #5 CLK = ~CLK;

    uart_host_cmd_seq #(
        .ADDR_WIDTH     (4),
        .RSP_BYTES      (2),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_type      (cmd_type),
        .cmd_addr      (cmd_addr),
        .cmd_data      (cmd_data),
        .cmd_op_b      (cmd_op_b),
        .cmd_fun       (cmd_fun),
        .tx_byte       (tx_byte),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_byte       (rx_byte),
        .rx_valid      (rx_valid),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_timeout   (rsp_timeout),
        .rx_unexpected (rx_unexpected),
        .busy          (busy)
    );

    typedef struct packed {
        logic [15:0] data;
        logic        to;
    } rsp_t;

    int   n_cmp = 0;
    int   n_err = 0;
    int   unexp_cnt = 0;
    logic [7:0] exp_tx[$];
    rsp_t exp_rsp[$];
    rsp_t mon_e;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a tx byte or a response.
    always @(negedge CLK) begin
        if (!RST) begin
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL tx_extra: got byte %0h expected none", tx_byte);
                end else begin
                    check("tx_byte", {24'h0, tx_byte}, {24'h0, exp_tx.pop_front()});
                end
            end
            if (rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rsp_extra: got data %0h expected none", rsp_data);
                end else begin
                    mon_e = exp_rsp.pop_front();
                    check("rsp_data", {16'h0, rsp_data}, {16'h0, mon_e.data});
                    check("rsp_timeout", {31'h0, rsp_timeout}, {31'h0, mon_e.to});
                end
            end
            if (rx_unexpected) unexp_cnt++;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] t, input logic [3:0] a,
                            input logic [7:0] d, input logic [7:0] b,
                            input logic [3:0] f);
        bit got;
        got = 1'b0;
        cmd_type  = t;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_op_b  = b;
        cmd_fun   = f;
        cmd_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge CLK);
            if (cmd_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL cmd_accept: got cmd_ready 0 expected 1 within 50 cycles");
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc);
        bit got;
        got = 1'b0;
        cyc = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            cyc++;
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL rsp_wait: got no rsp_valid expected one within 200 cycles");
        end
        tick();
    endtask

    initial begin
        int cyc;
        int u;

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        tick();
        RST = 1'b0;
        @(negedge CLK);
        check("post_rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        check("post_rst_busy", {31'h0, busy}, 32'h0);
        check("post_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("post_rst_rsp_data", {16'h0, rsp_data}, 32'h0);
        check("post_rst_rsp_timeout", {31'h0, rsp_timeout}, 32'h0);
        check("post_rst_rx_unexp", {31'h0, rx_unexpected}, 32'h0);
        tick();

        // 1: RF_WR, back-to-back bytes, completion one cycle after last byte
        tx_ready = 1'b1;
        exp_tx.push_back(8'hAA); exp_tx.push_back(8'h03); exp_tx.push_back(8'h5A);
        exp_rsp.push_back('{data: 16'h0000, to: 1'b0});
        send_cmd(2'd0, 4'd3, 8'h5A, 8'h00, 4'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("t1_tx_valid", {31'h0, tx_valid}, 32'h1);
        end
        @(negedge CLK);
        check("t1_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        @(negedge CLK);
        check("t1_rsp_pulse", {31'h0, rsp_valid}, 32'h0);
        check("t1_back_idle", {31'h0, cmd_ready}, 32'h1);
        tick();

        // 2: RF_RD, one response byte; result held after the pulse
        exp_tx.push_back(8'hBB); exp_tx.push_back(8'h02);
        exp_rsp.push_back('{data: 16'h0081, to: 1'b0});
        send_cmd(2'd1, 4'd2, 8'h00, 8'h00, 4'h0);
        tick(); tick();
        rx_send(8'h81);
        wait_rsp(cyc);
        check("t2_latency", cyc, 32'd1);
        @(negedge CLK);
        check("t2_hold_data", {16'h0, rsp_data}, 32'h0081);
        check("t2_hold_valid", {31'h0, rsp_valid}, 32'h0);
        tick();

        // Stray byte in IDLE
        u = unexp_cnt;
        rx_send(8'h55);
        tick();
        check("idle_rx_unexp", unexp_cnt, u + 1);

        // 3: ALU_OP, two response bytes LSB-first
        exp_tx.push_back(8'hCC); exp_tx.push_back(8'h12);
        exp_tx.push_back(8'h34); exp_tx.push_back(8'h00);
        exp_rsp.push_back('{data: 16'h0046, to: 1'b0});
        send_cmd(2'd2, 4'd0, 8'h12, 8'h34, 4'h0);
        repeat (4) tick();
        rx_send(8'h46);
        rx_send(8'h00);
        wait_rsp(cyc);
        check("t3_latency", cyc, 32'd1);

        // rx strobe on the final tx handshake is response byte 0
        u = unexp_cnt;
        exp_tx.push_back(8'hCC); exp_tx.push_back(8'h01);
        exp_tx.push_back(8'h02); exp_tx.push_back(8'h07);
        exp_rsp.push_back('{data: 16'h1177, to: 1'b0});
        send_cmd(2'd2, 4'd0, 8'h01, 8'h02, 4'h7);
        repeat (3) tick();
        rx_send(8'h77);
        rx_send(8'h11);
        wait_rsp(cyc);
        check("coinc_no_unexp", unexp_cnt, u);

        // 4: tx_ready stall mid-frame
        exp_tx.push_back(8'hCC); exp_tx.push_back(8'h9A);
        exp_tx.push_back(8'hBC); exp_tx.push_back(8'h05);
        exp_rsp.push_back('{data: 16'hF00D, to: 1'b0});
        send_cmd(2'd2, 4'd0, 8'h9A, 8'hBC, 4'h5);
        tick();
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("t4_stall_valid", {31'h0, tx_valid}, 32'h1);
            check("t4_stall_byte", {24'h0, tx_byte}, 32'h9A);
        end
        tick();
        tx_ready = 1'b1;
        repeat (3) tick();
        rx_send(8'h0D);
        rx_send(8'hF0);
        wait_rsp(cyc);

        // RF_WR with an rx byte on its final handshake: nothing expected, flagged
        u = unexp_cnt;
        exp_tx.push_back(8'hAA); exp_tx.push_back(8'h0F); exp_tx.push_back(8'hC3);
        exp_rsp.push_back('{data: 16'h0000, to: 1'b0});
        send_cmd(2'd0, 4'hF, 8'hC3, 8'h00, 4'h0);
        tick(); tick();
        rx_send(8'h99);
        wait_rsp(cyc);
        check("rfwr_rx_unexp", unexp_cnt, u + 1);

`ifdef HOST_RSP_TIMEOUT_EN
        // 5: ALU_NOP with one byte then silence
        exp_tx.push_back(8'hDD); exp_tx.push_back(8'h03);
        exp_rsp.push_back('{data: 16'h00AB, to: 1'b1});
        send_cmd(2'd3, 4'd0, 8'h00, 8'h00, 4'h3);
        tick(); tick();
        rx_send(8'hAB);
        wait_rsp(cyc);
        check("t5_timeout_latency", cyc, 32'd20);
`endif

        // 6: reset after the 2nd byte of an ALU_OP
        exp_tx.push_back(8'hCC); exp_tx.push_back(8'h21);
        send_cmd(2'd2, 4'd0, 8'h21, 8'h43, 4'h1);
        tick(); tick();
        RST = 1'b1;
        tx_ready = 1'b0;
        tick();
        @(negedge CLK);
        check("t6_tx_valid_drop", {31'h0, tx_valid}, 32'h0);
        check("t6_ready_in_rst", {31'h0, cmd_ready}, 32'h0);
        tick();
        RST = 1'b0;
        @(negedge CLK);
        check("t6_ready_after", {31'h0, cmd_ready}, 32'h1);
        check("t6_rsp_data_clr", {16'h0, rsp_data}, 32'h0);
        tick();
        u = unexp_cnt;
        rx_send(8'h3C);
        tick();
        check("t6_rx_unexp", unexp_cnt, u + 1);

        // Recovery after the abandoned frame
        tx_ready = 1'b1;
        exp_tx.push_back(8'hBB); exp_tx.push_back(8'h05);
        exp_rsp.push_back('{data: 16'h00E1, to: 1'b0});
        send_cmd(2'd1, 4'd5, 8'h00, 8'h00, 4'h0);
        tick(); tick();
        rx_send(8'hE1);
        wait_rsp(cyc);

        tick();
        check("tx_queue_drained", exp_tx.size(), 32'd0);
        check("rsp_queue_drained", exp_rsp.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
